// File: rtl/fp_mult_arbiter_pkg.sv
// ============================================================================
// Module  : fp_mult_arb_pkg
// Purpose : Shared types and constants for the fp_mult round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int STATUS_W  = 8;
  localparam int ZERO_B    = 0;
  localparam int INF_B     = 1;
  localparam int NAN_B     = 2;
  localparam int TINY_B    = 3;
  localparam int HUGE_B    = 4;
  localparam int INEXACT_B = 5;

  // Rounding mode encodings.
  localparam logic [2:0] RND_RNE = 3'd0;
  localparam logic [2:0] RND_RTZ = 3'd1;
  localparam logic [2:0] RND_RDN = 3'd2;
  localparam logic [2:0] RND_RUP = 3'd3;
  localparam logic [2:0] RND_RMM = 3'd4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
  } fpm_req_t;

endpackage

`default_nettype wire

// File: rtl/fp_mult_arbiter_fp_mult.sv
// ============================================================================
// Module  : fp_mult
// Purpose : Combinational IEEE-754 single multiply with rounding and status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mult
  import fp_mult_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [2:0]          rnd_i,
  output logic [31:0]         z_o,
  output logic [STATUS_W-1:0] status_o
);

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  logic        w_sign, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb, w_mant;
  logic [47:0] w_prod, w_norm;
  logic [5:0]  w_lz;
  logic [95:0] w_wide;
  logic        w_guard, w_sticky, w_inc, w_to_inf, w_ovf;
  logic [33:0] w_mag;
  int          w_exp, w_sh;

  always_comb begin
    w_sign   = a_i[31] ^ b_i[31];
    w_a_nan  = (&a_i[30:23]) && (|a_i[22:0]);
    w_b_nan  = (&b_i[30:23]) && (|b_i[22:0]);
    w_a_inf  = (&a_i[30:23]) && !(|a_i[22:0]);
    w_b_inf  = (&b_i[30:23]) && !(|b_i[22:0]);
    w_a_zero = !(|a_i[30:0]);
    w_b_zero = !(|b_i[30:0]);
    w_ea     = (|a_i[30:23]) ? a_i[30:23] : 8'd1;
    w_eb     = (|b_i[30:23]) ? b_i[30:23] : 8'd1;
    w_ma     = {|a_i[30:23], a_i[22:0]};
    w_mb     = {|b_i[30:23], b_i[22:0]};
    w_prod   = {24'd0, w_ma} * {24'd0, w_mb};
    w_lz     = '0;
    for (int i = 0; i < 48; i++) begin
      if (w_prod[i]) w_lz = 6'(47 - i);
    end
    w_norm   = w_prod << w_lz;
    w_exp    = int'(w_ea) + int'(w_eb) - 126 - int'(w_lz);
    // Results below the normal range are denormalised with exponent pinned at 1.
    w_sh     = (w_exp < 1) ? (((1 - w_exp) > 49) ? 49 : (1 - w_exp)) : 0;
    w_wide   = {w_norm, 48'd0} >> w_sh;
    w_mant   = w_wide[95:72];
    w_guard  = w_wide[71];
    w_sticky = |w_wide[70:0];
    case (rnd_i)
      RND_RTZ: w_inc = 1'b0;
      RND_RDN: w_inc = (w_guard | w_sticky) & w_sign;
      RND_RUP: w_inc = (w_guard | w_sticky) & ~w_sign;
      RND_RMM: w_inc = w_guard;
      default: w_inc = w_guard & (w_sticky | w_mant[0]);
    endcase
    case (rnd_i)
      RND_RTZ: w_to_inf = 1'b0;
      RND_RDN: w_to_inf = w_sign;
      RND_RUP: w_to_inf = ~w_sign;
      default: w_to_inf = 1'b1;
    endcase
    // (exp-1)<<23 plus the mantissa with hidden bit lets carries ripple into the exponent.
    w_mag = (34'((w_exp < 1) ? 0 : (w_exp - 1)) << 23) + 34'(w_mant) + 34'(w_inc);
    w_ovf = (w_mag >= 34'h07F800000);

    z_o      = '0;
    status_o = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      z_o             = 32'h7FC00000;
      status_o[NAN_B] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      z_o             = {w_sign, 31'h7F800000};
      status_o[INF_B] = 1'b1;
    end else if (w_a_zero || w_b_zero) begin
      z_o              = {w_sign, 31'd0};
      status_o[ZERO_B] = 1'b1;
    end else if (w_ovf) begin
      z_o                 = w_to_inf ? {w_sign, 31'h7F800000} : {w_sign, 31'h7F7FFFFF};
      status_o[HUGE_B]    = 1'b1;
      status_o[INEXACT_B] = 1'b1;
      status_o[INF_B]     = w_to_inf;
    end else begin
      z_o                 = {w_sign, w_mag[30:0]};
      status_o[ZERO_B]    = (w_mag[30:0] == 31'd0);
      status_o[TINY_B]    = (w_exp < 1);
      status_o[INEXACT_B] = w_guard | w_sticky;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_mult_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin selector starting after last_i.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  logic [ID_W-1:0] w_j;

  // Scan farthest-first so the nearest requester after last_i wins.
  always_comb begin
    idx_o = '0;
    w_j   = '0;
    any_o = |req_i;
    for (int k = N_REQ; k >= 1; k--) begin
      w_j = ID_W'((int'(last_i) + k) % N_REQ);
      if (req_i[w_j]) idx_o = w_j;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_mult_arbiter.sv
// ============================================================================
// Module  : fp_mult_arbiter
// Purpose : Round-robin sharing of one fp_mult among N_REQ requesters.
//           Optional per-requester sticky status under FPM_ARB_STICKY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mult_arbiter
  import fp_mult_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*32-1:0]          req_a,
  input  logic [N_REQ*32-1:0]          req_b,
  input  logic [N_REQ*3-1:0]           req_rnd,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(N_REQ)-1:0]     rsp_id,
  output logic [31:0]                  rsp_z,
  output logic [STATUS_W-1:0]          rsp_status,
  output logic                         busy
`ifdef FPM_ARB_STICKY_EN
  ,
  output logic [N_REQ*STATUS_W-1:0]    sticky_status,
  input  logic [N_REQ-1:0]             sticky_clr
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     last_q, id_q, w_pick;
  logic                w_any, w_fire;
  fpm_req_t            op_q;
  logic [31:0]         z_q, w_z;
  logic [STATUS_W-1:0] status_q, w_status;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .idx_o  (w_pick),
    .any_o  (w_any)
  );

  fp_mult u_fp_mult (
    .clk      (clk),
    .rst      (rst),
    .a_i      (op_q.a),
    .b_i      (op_q.b),
    .rnd_i    (op_q.rnd),
    .z_o      (w_z),
    .status_o (w_status)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (w_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = w_any ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A grant is only visible while out of reset so no requester sees a phantom accept.
  always_comb begin
    w_fire    = rst && w_any && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    req_ready = w_fire ? (N_REQ'(1) << w_pick) : '0;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= ID_W'(N_REQ - 1);
      id_q     <= '0;
      op_q     <= '0;
      z_q      <= '0;
      status_q <= '0;
    end else begin
      if (w_fire) begin
        last_q   <= w_pick;
        id_q     <= w_pick;
        op_q.a   <= req_a[32*w_pick +: 32];
        op_q.b   <= req_b[32*w_pick +: 32];
        op_q.rnd <= req_rnd[3*w_pick +: 3];
      end
      if (state_q == EXEC) begin
        z_q      <= w_z;
        status_q <= w_status;
      end
    end
  end

  assign rsp_id     = id_q;
  assign rsp_z      = z_q;
  assign rsp_status = status_q;

`ifdef FPM_ARB_STICKY_EN
  logic [N_REQ*STATUS_W-1:0] sticky_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (sticky_clr[i])
          sticky_q[i*STATUS_W +: STATUS_W] <= '0;
        else if (rsp_valid && rsp_ready && (id_q == ID_W'(i)))
          sticky_q[i*STATUS_W +: STATUS_W] <= sticky_q[i*STATUS_W +: STATUS_W] | status_q;
      end
    end
  end

  assign sticky_status = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_arbiter.sv
// ============================================================================
// Module  : tb_fp_mult_arbiter
// Purpose : Randomised scoreboard bench for fp_mult_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mult_arbiter;

  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*32-1:0]  req_a, req_b;
  logic [NR*3-1:0]   req_rnd;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_z;
  logic [7:0]        rsp_status;
`ifdef FPM_ARB_STICKY_EN
  logic [NR*8-1:0]   sticky_status;
  logic [NR-1:0]     sticky_clr = '0;
`endif

  fp_mult_arbiter #(.N_REQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rnd    (req_rnd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_status (rsp_status),
    .busy       (busy)
`ifdef FPM_ARB_STICKY_EN
    ,
    .sticky_status (sticky_status),
    .sticky_clr    (sticky_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  r;
    logic [31:0] z;
    logic [7:0]  s;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] z;
    logic [7:0]  s;
  } exp_t;

  vec_t    vt [16];
  exp_t    sbq [$];
  int      n_checks = 0;
  int      n_fail   = 0;
  bit [NR-1:0] pend = '0;
  int      vsel [NR];
  int      last_m;
  bit      inflight;
  int      age;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the latency/round-robin reference model.
  task automatic step(input bit rdy);
    logic [NR-1:0] exp_rdy;
    bit            exp_rv, can;
    int            g;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (pend[i]) begin
        req_a[32*i +: 32] = vt[vsel[i]].a;
        req_b[32*i +: 32] = vt[vsel[i]].b;
        req_rnd[3*i +: 3] = vt[vsel[i]].r;
      end else begin
        req_a[32*i +: 32] = $urandom();
        req_b[32*i +: 32] = $urandom();
        req_rnd[3*i +: 3] = 3'($urandom_range(0, 7));
      end
    end
    req_valid = pend;
    rsp_ready = rdy;
    #1;
    exp_rv = inflight && (age >= 2);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("busy", 64'(busy), 64'(inflight));
    can     = !inflight || (exp_rv && rdy);
    exp_rdy = '0;
    g       = -1;
    if (can) begin
      for (int k = 1; k <= NR; k++)
        if (g < 0 && pend[(last_m + k) % NR]) g = (last_m + k) % NR;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rv && rdy) inflight = 1'b0;
    if (g >= 0) begin
      sbq.push_back('{g, vt[vsel[g]].z, vt[vsel[g]].s});
      last_m   = g;
      pend[g]  = 1'b0;
      inflight = 1'b1;
      age      = 1;
    end else if (inflight && age < 2) begin
      age++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((inflight || sbq.size() != 0 || pend != '0) && k < 60) begin
      step(1'b1);
      k++;
    end
    if (inflight || sbq.size() != 0 || pend != '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: pending work remains after %0d cycles", k);
    end
  endtask

  // Monitor: peek the front entry while valid (covers hold stability), pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
          chk("rsp_z", 64'(rsp_z), 64'(sbq[0].z));
          chk("rsp_status", 64'(rsp_status), 64'(sbq[0].s));
          if (rsp_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h3F800000, 32'h40000000, 3'd0, 32'h40000000, 8'h00};
    vt[1]  = '{32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 8'h00};
    vt[2]  = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04};
    vt[3]  = '{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 8'h32};
    vt[4]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20};
    vt[5]  = '{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 8'h20};
    vt[6]  = '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h20};
    vt[7]  = '{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 8'h30};
    vt[8]  = '{32'hC0000000, 32'h40400000, 3'd0, 32'hC0C00000, 8'h00};
    vt[9]  = '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 8'h01};
    vt[10] = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 8'h08};
    vt[11] = '{32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04};
    vt[12] = '{32'h7F800000, 32'h40000000, 3'd0, 32'h7F800000, 8'h02};
    vt[13] = '{32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 8'h00};
    vt[14] = '{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 8'h32};
    vt[15] = '{32'h3F800001, 32'hBF800001, 3'd2, 32'hBF800003, 8'h20};
    for (int i = 0; i < NR; i++) vsel[i] = 0;

    // Reset state, with every requester asserting valid.
    rst       = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_rnd   = '0;
    rsp_ready = 1'b0;
    last_m    = NR - 1;
    inflight  = 1'b0;
    age       = 0;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_z", 64'(rsp_z), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_status", 64'(rsp_status), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;

    // Every vector once, spread across requesters.
    for (int v = 0; v < 16; v++) begin
      pend[v % NR] = 1'b1;
      vsel[v % NR] = v;
      drain();
    end

    // All requesters held valid: grants rotate 0,1,2,3,0,... and wrap.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NR; i++) begin
        pend[i] = 1'b1;
        vsel[i] = 1;
      end
      step(1'b1);
    end
    pend = '0;
    drain();

    // Backpressure: five stalled cycles, then the next grant rides the handshake.
    pend[0] = 1'b1;
    vsel[0] = 13;
    step(1'b1);
    step(1'b1);
    pend[1] = 1'b1; vsel[1] = 3;
    pend[2] = 1'b1; vsel[2] = 8;
    for (int n = 0; n < 5; n++) step(1'b0);
    step(1'b1);
    drain();

    // Reset while a transaction is in EXEC.
    pend = '1;
    for (int i = 0; i < NR; i++) vsel[i] = 1;
    step(1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_rsp_z", 64'(rsp_z), 64'd0);
    sbq.delete();
    inflight  = 1'b0;
    age       = 0;
    last_m    = NR - 1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1);
    drain();

    // Randomised traffic, including requesters that withdraw before a grant.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          vsel[i] = int'($urandom_range(0, 15));
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step(bit'($urandom_range(0, 3) != 0));
    end
    pend = '0;
    drain();

`ifdef FPM_ARB_STICKY_EN
    sticky_clr = '1;
    step(1'b1);
    sticky_clr = '0;
    pend[1] = 1'b1; vsel[1] = 4;
    drain();
    pend[1] = 1'b1; vsel[1] = 0;
    drain();
    @(negedge clk);
    #1;
    chk("sticky_1_or", 64'(sticky_status[15:8]), 64'h20);
    sticky_clr = 4'b0010;
    step(1'b1);
    sticky_clr = '0;
    @(negedge clk);
    #1;
    chk("sticky_1_clr", 64'(sticky_status[15:8]), 64'h00);
`endif

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
